// File: rtl/pointer_addr_unit_pkg.sv
// Shared encodings for the pointer/address stage: enable-bit indices,
// pointer-select codes and memory request decoding.
package pointer_addr_unit_pkg;

  localparam int unsigned RO_GSP = 2;
  localparam int unsigned RO_RP  = 3;
  localparam int unsigned RO_CP  = 4;
  localparam int unsigned RO_STP = 5;

  typedef enum logic [1:0] {
    P_GSP = 2'd0,
    P_RP  = 2'd1,
    P_CP  = 2'd2,
    P_STP = 2'd3
  } ptr_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE     = 2'd0,
    MEM_RD       = 2'd1,
    MEM_WR       = 2'd2,
    MEM_CONFLICT = 2'd3
  } mem_op_e;

  function automatic mem_op_e decode_mem(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return MEM_RD;
      2'b01:   return MEM_WR;
      2'b11:   return MEM_CONFLICT;
      default: return MEM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pointer_addr_unit_ptr_reg.sv
// Single memory pointer register: clear > write > increment, with a sticky
// flag recording an increment that wrapped from all-ones to zero.
module ptr_reg #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_en,
  input  logic              wrt_en,
  input  logic              inc_en,
  input  logic [DATA_W-1:0] bus_in,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap
);

  logic [ADDR_W-1:0] wr_val;

  if (DATA_W >= ADDR_W) begin : g_trunc
    assign wr_val = bus_in[ADDR_W-1:0];
    if (DATA_W > ADDR_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^bus_in[DATA_W-1:ADDR_W];
    end
  end else begin : g_zext
    assign wr_val = {{(ADDR_W-DATA_W){1'b0}}, bus_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (rst_en) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (wrt_en) begin
      ptr <= wr_val;
    end else if (inc_en) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) wrap <= 1'b1;
    end
  end

endmodule

// File: rtl/pointer_addr_unit.sv
// Memory pointer bank (GSP/RP/CP/STP) with registered RAM address, single-cycle
// read/write strobes and a read-data-valid flag delayed by the RAM latency.
module pointer_addr_unit
  import pointer_addr_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [13:0]       wrt_en,
  input  logic [13:0]       inc_en,
  input  logic [13:0]       rst_en,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [1:0]        p_ctrl,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [ADDR_W-1:0] gsp_out,
  output logic [ADDR_W-1:0] rp_out,
  output logic [ADDR_W-1:0] cp_out,
  output logic [ADDR_W-1:0] stp_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic              rd_valid,
  output logic [3:0]        wrap_flags,
  output logic              ctrl_err
);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("pointer_addr_unit: RD_LAT must be 1 or 2");
  end

  logic unused_en;
  assign unused_en = ^{wrt_en[13:6], wrt_en[1:0],
                       inc_en[13:6], inc_en[1:0],
                       rst_en[13:6], rst_en[1:0]};

  logic gsp_wrap, rp_wrap, cp_wrap, stp_wrap;

  ptr_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gsp (
    .clk(clk), .rst(rst), .rst_en(rst_en[RO_GSP]), .wrt_en(wrt_en[RO_GSP]),
    .inc_en(inc_en[RO_GSP]), .bus_in(bus_in), .ptr(gsp_out), .wrap(gsp_wrap)
  );

  ptr_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rp (
    .clk(clk), .rst(rst), .rst_en(rst_en[RO_RP]), .wrt_en(wrt_en[RO_RP]),
    .inc_en(inc_en[RO_RP]), .bus_in(bus_in), .ptr(rp_out), .wrap(rp_wrap)
  );

  ptr_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cp (
    .clk(clk), .rst(rst), .rst_en(rst_en[RO_CP]), .wrt_en(wrt_en[RO_CP]),
    .inc_en(inc_en[RO_CP]), .bus_in(bus_in), .ptr(cp_out), .wrap(cp_wrap)
  );

  ptr_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_stp (
    .clk(clk), .rst(rst), .rst_en(rst_en[RO_STP]), .wrt_en(wrt_en[RO_STP]),
    .inc_en(inc_en[RO_STP]), .bus_in(bus_in), .ptr(stp_out), .wrap(stp_wrap)
  );

  assign wrap_flags = {stp_wrap, cp_wrap, rp_wrap, gsp_wrap};

  // Mux reads the pointer registers' current outputs, so a same-edge update
  // is only visible on ram_addr one cycle later.
  logic [ADDR_W-1:0] sel_ptr;

  always_comb begin
    sel_ptr = '0;
    case (ptr_sel_e'(p_ctrl))
      P_GSP:   sel_ptr = gsp_out;
      P_RP:    sel_ptr = rp_out;
      P_CP:    sel_ptr = cp_out;
      P_STP:   sel_ptr = stp_out;
      default: sel_ptr = '0;
    endcase
  end

  mem_op_e mem_op;
  assign mem_op = decode_mem(mem_read, mem_write);

  logic [RD_LAT-1:0] rd_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      ctrl_err <= 1'b0;
      rd_pipe  <= '0;
    end else begin
      ram_addr <= sel_ptr;
      ram_re   <= (mem_op == MEM_RD);
      ram_we   <= (mem_op == MEM_WR);
      if (mem_op == MEM_CONFLICT) ctrl_err <= 1'b1;
      rd_pipe[0] <= ram_re;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_valid = rd_pipe[RD_LAT-1];

endmodule

// File: tb/tb_pointer_addr_unit.sv
// Directed-vector bench: stimulus queues hand-computed expectations tagged with
// the cycle they fall due; a negedge monitor retires and compares them.
module tb_pointer_addr_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [13:0]       wrt_en, inc_en, rst_en;
  logic [DATA_W-1:0] bus_in;
  logic [1:0]        p_ctrl;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] gsp_out, rp_out, cp_out, stp_out, ram_addr;
  logic              ram_re, ram_we, rd_valid, ctrl_err;
  logic [3:0]        wrap_flags;

  pointer_addr_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .wrt_en(wrt_en), .inc_en(inc_en), .rst_en(rst_en),
    .bus_in(bus_in), .p_ctrl(p_ctrl), .mem_read(mem_read), .mem_write(mem_write),
    .gsp_out(gsp_out), .rp_out(rp_out), .cp_out(cp_out), .stp_out(stp_out),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .rd_valid(rd_valid),
    .wrap_flags(wrap_flags), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  typedef enum int unsigned {
    F_GSP, F_RP, F_CP, F_STP, F_ADDR, F_RE, F_WE, F_RV, F_WRAP, F_ERR
  } fld_e;

  typedef struct {
    int unsigned due;
    fld_e        fld;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input fld_e f);
    case (f)
      F_GSP:   return gsp_out;
      F_RP:    return rp_out;
      F_CP:    return cp_out;
      F_STP:   return stp_out;
      F_ADDR:  return ram_addr;
      F_RE:    return {15'd0, ram_re};
      F_WE:    return {15'd0, ram_we};
      F_RV:    return {15'd0, rd_valid};
      F_WRAP:  return {12'd0, wrap_flags};
      default: return {15'd0, ctrl_err};
    endcase
  endfunction

  function automatic string fname(input fld_e f);
    case (f)
      F_GSP:   return "gsp_out";
      F_RP:    return "rp_out";
      F_CP:    return "cp_out";
      F_STP:   return "stp_out";
      F_ADDR:  return "ram_addr";
      F_RE:    return "ram_re";
      F_WE:    return "ram_we";
      F_RV:    return "rd_valid";
      F_WRAP:  return "wrap_flags";
      default: return "ctrl_err";
    endcase
  endfunction

  // Monitor: retire every expectation due in the cycle just completed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [15:0] a;
        a = actual(sb[i].fld);
        tests++;
        if (a !== sb[i].val) begin
          fails++;
          $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                   fname(sb[i].fld), cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int unsigned dly, input fld_e f, input logic [15:0] v);
    exp_t e;
    e.due = cyc + dly;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input int unsigned dly);
    for (int unsigned f = 0; f <= 9; f++) expect_at(dly, fld_e'(f), 16'h0);
  endtask

  task automatic idle();
    wrt_en = '0; inc_en = '0; rst_en = '0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; idle(); bus_in = '0; p_ctrl = 2'd0;
    expect_all_zero(1);
    tick();
    tick();

    // Reset mid-read: the read in flight must not produce rd_valid
    rst = 1'b0; mem_read = 1'b1;
    expect_at(1, F_RE, 16'h1);
    tick();
    rst = 1'b1; mem_read = 1'b0;
    expect_all_zero(1);
    expect_at(2, F_RV, 16'h0);
    expect_at(3, F_RV, 16'h0);
    tick();
    rst = 1'b0;
    tick();

    // Priority on RP
    wrt_en[3] = 1'b1; bus_in = 16'h0010;
    expect_at(1, F_RP, 16'h0010);
    tick();
    rst_en[3] = 1'b1; inc_en[3] = 1'b1; bus_in = 16'h1234;
    expect_at(1, F_RP, 16'h0000);
    tick();
    rst_en[3] = 1'b0;
    expect_at(1, F_RP, 16'h1234);
    tick();
    idle();

    // GSP wrap, with an independent RP increment in the same cycle
    wrt_en[2] = 1'b1; bus_in = 16'hFFFF;
    expect_at(1, F_GSP, 16'hFFFF);
    tick();
    idle(); inc_en[2] = 1'b1; inc_en[3] = 1'b1;
    expect_at(1, F_GSP, 16'h0000);
    expect_at(1, F_RP, 16'h1235);
    expect_at(1, F_WRAP, 16'h0001);
    tick();
    idle(); rst_en[2] = 1'b1;
    expect_at(1, F_WRAP, 16'h0000);
    tick();
    idle();

    // STP wrap lands in the top flag bit
    wrt_en[5] = 1'b1; bus_in = 16'hFFFF;
    tick();
    idle(); inc_en[5] = 1'b1;
    expect_at(1, F_STP, 16'h0000);
    expect_at(1, F_WRAP, 16'h0008);
    tick();
    idle(); rst_en[5] = 1'b1;
    expect_at(1, F_WRAP, 16'h0000);
    tick();

    // Address and write timing
    idle(); wrt_en[5] = 1'b1; bus_in = 16'h0040;
    tick();
    idle(); p_ctrl = 2'd3;
    expect_at(1, F_ADDR, 16'h0040);
    expect_at(1, F_WE, 16'h0);
    tick();
    mem_write = 1'b1;
    expect_at(1, F_WE, 16'h1);
    expect_at(1, F_ADDR, 16'h0040);
    tick();
    mem_write = 1'b0;
    expect_at(1, F_WE, 16'h0);
    tick();
    // Selected pointer rewritten: address follows two cycles later
    wrt_en[5] = 1'b1; bus_in = 16'h0077;
    expect_at(1, F_ADDR, 16'h0040);
    expect_at(2, F_ADDR, 16'h0077);
    tick();
    idle();
    tick();

    // Read latency with back-to-back reads
    wrt_en[4] = 1'b1; bus_in = 16'h0005; p_ctrl = 2'd2;
    tick();
    idle(); mem_read = 1'b1;
    expect_at(1, F_RE, 16'h1);
    expect_at(1, F_RV, 16'h0);
    expect_at(1, F_ADDR, 16'h0005);
    expect_at(1 + RD_LAT, F_RV, 16'h1);
    expect_at(2 + RD_LAT, F_RV, 16'h1);
    expect_at(3 + RD_LAT, F_RV, 16'h0);
    tick();
    expect_at(1, F_RE, 16'h1);
    tick();
    mem_read = 1'b0;
    expect_at(1, F_RE, 16'h0);
    tick();
    tick();
    tick();

    // Conflict: strobes suppressed, error sticky until reset
    mem_read = 1'b1; mem_write = 1'b1;
    expect_at(1, F_RE, 16'h0);
    expect_at(1, F_WE, 16'h0);
    expect_at(1, F_ERR, 16'h1);
    tick();
    idle();
    expect_at(1, F_ERR, 16'h1);
    expect_at(3, F_ERR, 16'h1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    expect_all_zero(1);
    tick();
    rst = 1'b0;
    tick();

    for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
    if (sb.size() != 0) begin
      fails += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pointer_addr_unit.md
Name: pointer_addr_unit

Overview:
- Datapath stage directly downstream of the control unit's pointer and memory control outputs.
- Holds the four memory pointer registers: GSP (bit 2), RP (bit 3), CP (bit 4) and STP (bit 5) of the 14-bit enable vectors.
- Applies the control unit's reset, write and increment enables to them, and muxes the selected pointer onto a registered RAM address.
- Sequences single-cycle RAM read/write strobes with a one-cycle read-data-valid flag.

Parameters:
- ADDR_W, 16, width of every pointer register and of ram_addr.
- DATA_W, 16, width of the shared data bus feeding pointer writes.
- RD_LAT, 1, synchronous RAM read latency in cycles; legal values are 1 or 2.

Ports:
- clk  in  1  system clock; this block samples on the rising edge (the control unit drives on the falling edge).
- rst  in  1  synchronous, active-high reset.
- wrt_en  in  14  register write enables; bits 2..5 are used, all others ignored.
- inc_en  in  14  register increment enables; bits 2..5 are used.
- rst_en  in  14  register clear enables; bits 2..5 are used.
- bus_in  in  DATA_W  shared data bus; source for pointer writes.
- p_ctrl  in  2  pointer select: 0=GSP, 1=RP, 2=CP, 3=STP.
- mem_read  in  1  read request.
- mem_write  in  1  write request.
- gsp_out, rp_out, cp_out, stp_out  out  ADDR_W each  current pointer values, to the bus mux.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- rd_valid  out  1  RAM output data is valid this cycle.
- wrap_flags  out  4  sticky per-pointer increment-wrap flags, ordered {STP,CP,RP,GSP}.
- ctrl_err  out  1  sticky flag: read and write requested together.

Behaviour:
- Reset (rst=1 at a rising edge): all pointers, ram_addr, ram_re, ram_we, rd_valid, wrap_flags and ctrl_err go to 0. The read-latency pipeline is flushed, so a read in flight produces no rd_valid.
- Per-pointer update each edge, priority rst_en > wrt_en > inc_en:
  - rst_en: pointer <= 0; that pointer's wrap flag is cleared.
  - wrt_en: pointer <= bus_in[ADDR_W-1:0], zero-extended if DATA_W < ADDR_W.
  - inc_en: pointer <= pointer+1 modulo 2^ADDR_W. When incrementing from all-ones, the pointer goes to 0 and its wrap flag is set.
  - Enables on different pointers are independent and may act in the same cycle.
- Address path:
  - ram_addr <= pointer selected by p_ctrl, one cycle of latency.
  - It uses the pointer value from before any update in the same edge. A pointer written or incremented in cycle N therefore appears on ram_addr at N+2 if still selected.
  - ram_addr updates every cycle, regardless of the request inputs.
- Strobes:
  - ram_re <= mem_read & ~mem_write.
  - ram_we <= mem_write & ~mem_read.
  - Both are registered alongside ram_addr, so a request and its address reach the RAM in the same cycle.
  - The control unit holds p_ctrl one cycle ahead of mem_write (STSP_1/STSP_2); this registration keeps them aligned.
- Conflict: mem_read and mem_write both 1 sets ctrl_err (sticky until rst). Both strobes are forced to 0 for that cycle.
- rd_valid pulses high exactly RD_LAT cycles after ram_re is high, for one cycle per read. Back-to-back reads give back-to-back rd_valid pulses.
- Pointer outputs are register outputs, combinationally unaltered.
- No state machine beyond the RD_LAT shift pipeline. All state is plain registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package/define file holds:
  - enable-bit indices: RO_GSP=2, RO_RP=3, RO_CP=4, RO_STP=5;
  - p_ctrl encodings: P_GSP=0, P_RP=1, P_CP=2, P_STP=3;
  - memory-control encodings.
- One natural sub-module, ptr_reg: a single pointer register with rst/wrt/inc priority and a wrap flag, instantiated four times.

Test Plan:
- Reset mid-read:
  - Stimulus: mem_read=1, then rst=1 on the next cycle.
  - Required: no rd_valid pulse; all outputs 0.
- Priority:
  - Stimulus: RP=0x0010, with rst_en[3], wrt_en[3] and inc_en[3] all set, bus_in=0x1234.
  - Required: RP=0; then with wrt_en[3] and inc_en[3] together, RP=0x1234.
- Wrap:
  - Stimulus: GSP=0xFFFF, inc_en[2] for one cycle.
  - Required: GSP=0x0000 and wrap_flags=4'b0001; a following rst_en[2] clears the flag.
- Address and write timing:
  - Stimulus: STP=0x0040, p_ctrl=3 at cycle N, mem_write=1 at N+1.
  - Required: ram_addr=0x0040 from N+1; ram_we=1 during N+2 only.
- Read latency:
  - Stimulus: CP=0x0005, p_ctrl=2, mem_read=1 for 2 consecutive cycles.
  - Required: ram_re high for 2 cycles; rd_valid high for 2 cycles starting RD_LAT after ram_re rises.
- Conflict:
  - Stimulus: mem_read=mem_write=1 for one cycle.
  - Required: ram_re=ram_we=0 that cycle; ctrl_err=1 and held until rst.
